// File: rtl/vend_pkg.sv
// Shared encodings and coin constants for the credit-based vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CREDIT = 2'b01,
        VEND   = 2'b10,
        CHANGE = 2'b11
    } state_t;

    localparam int unsigned FIFTY_UNITS  = 1;
    localparam int unsigned DOLLAR_UNITS = 2;

    // Value of the coins presented in one cycle, in 50c units (0..3).
    function automatic logic [1:0] coin_value(input logic fifty, input logic dollar);
        logic [1:0] v;
        v = 2'd0;
        if (fifty)  v = v + 2'(FIFTY_UNITS);
        if (dollar) v = v + 2'(DOLLAR_UNITS);
        return v;
    endfunction

endpackage

// File: rtl/vend_credit_fsm_if.sv
// Coin-acceptor / actuator bundle between the front end and the controller.
interface vend_credit_fsm_if #(
    parameter int CREDIT_W = 4,
    parameter int STOCK_W  = 3
);
    import vend_pkg::*;

    logic                fifty;
    logic                dollar;
    logic                cancel;
    logic                restock;
    state_t              st;
    logic [CREDIT_W-1:0] credit;
    logic [STOCK_W-1:0]  stock;
    logic                insert_coin;
    logic                dispense;
    logic                money_return;
    logic                coin_reject;
    logic                sold_out;

    modport master (
        output fifty, dollar, cancel, restock,
        input  st, credit, stock, insert_coin, dispense, money_return, coin_reject, sold_out
    );

    modport slave (
        input  fifty, dollar, cancel, restock,
        output st, credit, stock, insert_coin, dispense, money_return, coin_reject, sold_out
    );

endinterface

// File: rtl/vend_stock_counter.sv
// Item stock counter: reload on restock, count down per vend, flag empty.
module vend_stock_counter #(
    parameter int STOCK_INIT = 3,
    parameter int STOCK_MAX  = 7,
    parameter int STOCK_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dec,
    output logic [STOCK_W-1:0] stock,
    output logic               zero
);

    assign zero = (stock == '0);

    // Stock register; decrement is guarded so the count can never wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stock <= STOCK_W'(STOCK_INIT);
        end else if (load) begin
            stock <= STOCK_W'(STOCK_MAX);
        end else if (dec && !zero) begin
            stock <= stock - STOCK_W'(1);
        end
    end

endmodule

// File: rtl/vend_credit_fsm.sv
// Credit accumulator and vend/change sequencer with stock lockout.
//   state  | meaning
//   IDLE   | no credit held, waiting for coins or restock
//   CREDIT | partial credit held, below price
//   VEND   | one-cycle dispense, price and one item consumed
//   CHANGE | returning leftover credit one unit per cycle
module vend_credit_fsm
    import vend_pkg::*;
#(
    parameter int PRICE_UNITS = 2,
    parameter int MAX_CREDIT  = 6,
    parameter int CREDIT_W    = 4,
    parameter int STOCK_INIT  = 3,
    parameter int STOCK_MAX   = 7,
    parameter int STOCK_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    vend_credit_fsm_if.slave bus
);

    localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE_UNITS);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_UNITS);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;
    logic                stock_load, stock_dec;
    logic                sold_out;
    logic [1:0]          coin_v;
    logic [CREDIT_W:0]   sum;
    logic                has_coin;
    logic                accept_ok;

    // Extra headroom bit so credit + v cannot wrap before the limit compare.
    assign coin_v    = coin_value(bus.fifty, bus.dollar);
    assign sum       = {1'b0, credit_q} + (CREDIT_W+1)'(coin_v);
    assign has_coin  = (coin_v != 2'd0);
    assign accept_ok = !sold_out && (sum <= MAX_X);

    vend_stock_counter #(
        .STOCK_INIT (STOCK_INIT),
        .STOCK_MAX  (STOCK_MAX),
        .STOCK_W    (STOCK_W)
    ) u_stock (
        .clk   (clk),
        .rst   (rst),
        .load  (stock_load),
        .dec   (stock_dec),
        .stock (bus.stock),
        .zero  (sold_out)
    );

    // State, credit and reject-flag registers; reset drops any pending change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    // Next-state, credit update and stock strobes.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        reject_d   = 1'b0;
        stock_load = 1'b0;
        stock_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                stock_load = bus.restock;
                if (has_coin) begin
                    if (accept_ok) begin
                        credit_d = sum[CREDIT_W-1:0];
                        state_d  = (sum >= PRICE_X) ? VEND : CREDIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            CREDIT: begin
                if (bus.cancel) begin
                    reject_d = has_coin;
                    state_d  = CHANGE;
                end else if (has_coin) begin
                    if (accept_ok) begin
                        credit_d = sum[CREDIT_W-1:0];
                        if (sum >= PRICE_X) state_d = VEND;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            VEND: begin
                reject_d  = has_coin;
                stock_dec = 1'b1;
                credit_d  = credit_q - PRICE_C;
                state_d   = (credit_q > PRICE_C) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_d = has_coin;
                if (credit_q != '0) credit_d = credit_q - CREDIT_W'(1);
                if (credit_q <= CREDIT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.st           = state_q;
    assign bus.credit       = credit_q;
    assign bus.coin_reject  = reject_q;
    assign bus.sold_out     = sold_out;
    assign bus.insert_coin  = ((state_q == IDLE) || (state_q == CREDIT)) && !sold_out;
    assign bus.dispense     = (state_q == VEND);
    assign bus.money_return = (state_q == CHANGE);

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Scoreboard bench: two builds (price 2 / max 6, and price 5 / max 6) share one
// stimulus stream; a transaction-level model predicts each post-edge snapshot.
module tb_vend_credit_fsm;
    import vend_pkg::*;

    localparam int STOCK_INIT = 3;
    localparam int STOCK_MAX  = 7;

    typedef struct {
        int credit;
        int stock;
        bit vend;
        bit refunding;
        bit rej;
    } mdl_t;

    typedef struct {
        int st;
        int credit;
        int stock;
        bit ic;
        bit disp;
        bit mr;
        bit rej;
        bit so;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vend_credit_fsm_if #(.CREDIT_W(4), .STOCK_W(3)) bus0 ();
    vend_credit_fsm_if #(.CREDIT_W(4), .STOCK_W(3)) bus1 ();

    vend_credit_fsm #(.PRICE_UNITS(2), .MAX_CREDIT(6), .CREDIT_W(4),
                      .STOCK_INIT(STOCK_INIT), .STOCK_MAX(STOCK_MAX), .STOCK_W(3))
        dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    vend_credit_fsm #(.PRICE_UNITS(5), .MAX_CREDIT(6), .CREDIT_W(4),
                      .STOCK_INIT(STOCK_INIT), .STOCK_MAX(STOCK_MAX), .STOCK_W(3))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    mdl_t m0, m1;
    exp_t q0[$];
    exp_t q1[$];
    int   vectors = 0;
    int   miscompares = 0;

    // One clock edge of the vending rules, in plain arithmetic.
    function automatic mdl_t step(input mdl_t m, input int price, input int maxc,
                                  input bit rst_n, input bit f, input bit d,
                                  input bit c, input bit r);
        int  v;
        bit  empty;
        v = (f ? 1 : 0) + (d ? 2 : 0);
        if (!rst_n) begin
            m.credit = 0; m.stock = STOCK_INIT; m.vend = 0; m.refunding = 0; m.rej = 0;
        end else if (m.vend) begin
            m.credit    = m.credit - price;
            m.stock     = m.stock - 1;
            m.vend      = 0;
            m.refunding = (m.credit > 0);
            m.rej       = (v > 0);
        end else if (m.refunding) begin
            m.credit    = m.credit - 1;
            m.refunding = (m.credit > 0);
            m.rej       = (v > 0);
        end else begin
            m.rej = 0;
            empty = (m.stock == 0);
            if (m.credit > 0 && c) begin
                m.refunding = 1;
                m.rej       = (v > 0);
            end else begin
                if (m.credit == 0 && r) m.stock = STOCK_MAX;
                if (v > 0) begin
                    if (empty || m.credit + v > maxc) m.rej = 1;
                    else begin
                        m.credit = m.credit + v;
                        if (m.credit >= price) m.vend = 1;
                    end
                end
            end
        end
        return m;
    endfunction

    function automatic exp_t observe(input mdl_t m);
        exp_t e;
        e.st     = m.vend ? 2 : (m.refunding ? 3 : (m.credit > 0 ? 1 : 0));
        e.credit = m.credit;
        e.stock  = m.stock;
        e.disp   = m.vend;
        e.mr     = m.refunding;
        e.rej    = m.rej;
        e.so     = (m.stock == 0);
        e.ic     = !m.vend && !m.refunding && (m.stock != 0);
        return e;
    endfunction

    // Drive one cycle of inputs on the falling edge and queue the predicted result.
    task automatic cyc(input bit f, input bit d, input bit c, input bit r, input bit rst_n);
        @(negedge clk);
        rst = rst_n;
        bus0.fifty = f; bus0.dollar = d; bus0.cancel = c; bus0.restock = r;
        bus1.fifty = f; bus1.dollar = d; bus1.cancel = c; bus1.restock = r;
        m0 = step(m0, 2, 6, rst_n, f, d, c, r);
        m1 = step(m1, 5, 6, rst_n, f, d, c, r);
        q0.push_back(observe(m0));
        q1.push_back(observe(m1));
    endtask

    task automatic chk(input string name, input int act, input int req);
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input int st, input int credit,
                           input int stock, input bit ic, input bit disp, input bit mr,
                           input bit rej, input bit so);
        vectors++;
        chk({tag, ".st"},           st,     e.st);
        chk({tag, ".credit"},       credit, e.credit);
        chk({tag, ".stock"},        stock,  e.stock);
        chk({tag, ".insert_coin"},  ic,     e.ic);
        chk({tag, ".dispense"},     disp,   e.disp);
        chk({tag, ".money_return"}, mr,     e.mr);
        chk({tag, ".coin_reject"},  rej,    e.rej);
        chk({tag, ".sold_out"},     so,     e.so);
    endtask

    // Monitors: sample just after each rising edge and retire one prediction.
    always begin
        @(posedge clk);
        #1;
        if (q0.size() > 0) begin
            exp_t e;
            e = q0.pop_front();
            compare("p2", e, int'(bus0.st), int'(bus0.credit), int'(bus0.stock),
                    bus0.insert_coin, bus0.dispense, bus0.money_return,
                    bus0.coin_reject, bus0.sold_out);
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (q1.size() > 0) begin
            exp_t e;
            e = q1.pop_front();
            compare("p5", e, int'(bus1.st), int'(bus1.credit), int'(bus1.stock),
                    bus1.insert_coin, bus1.dispense, bus1.money_return,
                    bus1.coin_reject, bus1.sold_out);
        end
    end

    initial begin
        int waited;
        bus0.fifty = 0; bus0.dollar = 0; bus0.cancel = 0; bus0.restock = 0;
        bus1.fifty = 0; bus1.dollar = 0; bus1.cancel = 0; bus1.restock = 0;
        m0 = '{default: 0};
        m1 = '{default: 0};

        // Reset, then idle.
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        // fifty, fifty -> vend without change.
        cyc(1, 0, 0, 0, 1); cyc(1, 0, 0, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);
        // fifty, dollar -> vend plus one change pulse.
        cyc(1, 0, 0, 0, 1); cyc(0, 1, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        // Both coins at once, then fifty followed by cancel with a dollar.
        cyc(1, 1, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 1); cyc(0, 1, 1, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);
        // Second build: 4 units then 3 more overflows its limit of 6.
        cyc(0, 1, 0, 0, 1); cyc(0, 1, 0, 0, 1); cyc(1, 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 1);
        repeat (6) cyc(0, 0, 0, 0, 1);
        // Drain stock, try a coin while sold out, restock.
        repeat (8) begin
            cyc(0, 1, 0, 0, 1);
            repeat (2) cyc(0, 0, 0, 0, 1);
        end
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);
        // Reset in the middle of a two-pulse refund.
        cyc(1, 0, 0, 0, 1); cyc(1, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                ($urandom % 16) == 0, ($urandom % 150) != 0);
        end

        waited = 0;
        while ((q0.size() > 0 || q1.size() > 0) && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (q0.size() > 0 || q1.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
